// File: rtl/cnn_mul_share_arb.sv
// Round-robin arbiter that time-multiplexes one signed A_W x B_W multiplier
// among NUM_REQ requesters. It uses a 2-stage pipeline with a backpressurable response port.
module cnn_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int A_W     = 10,
    parameter int B_W     = 14,
    parameter int P_W     = 25
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     cfg_mask,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [P_W-1:0]         rsp_p,
    output logic                   busy
);

    logic [ID_W-1:0]       rr_ptr_r;
    logic                  s1_v_r;
    logic signed [A_W-1:0] s1_a_r;
    logic signed [B_W-1:0] s1_b_r;
    logic [ID_W-1:0]       s1_id_r;
    logic                  s2_v_r;
    logic [P_W-1:0]        s2_p_r;
    logic [ID_W-1:0]       s2_id_r;

    logic [NUM_REQ-1:0]    eligible_s;
    logic                  grant_found_s;
    logic [ID_W-1:0]       grant_idx_s;
    logic [ID_W-1:0]       cand_idx_s;
    int                    cand_s;
    logic                  s2_hold_s;
    logic                  adv_s;
    logic                  xfer_s;
    logic signed [P_W-1:0] prod_s;

    assign eligible_s = req_valid & cfg_mask;
    assign s2_hold_s  = s2_v_r & ~rsp_ready;
    assign adv_s      = ~s1_v_r | ~s2_hold_s;

    // Round-robin search: first eligible requester at or after rr_ptr, wrapping
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = 0;
        cand_idx_s    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_s = int'(rr_ptr_r) + off;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = cand_s[ID_W-1:0];
            if (!grant_found_s && eligible_s[cand_idx_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_idx_s;
            end else begin
                grant_found_s = grant_found_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // One-hot grant, gated by pipeline advance and held off during reset
    always_comb begin
        req_ready = '0;
        if (grant_found_s && adv_s && ap_rst_n) begin
            req_ready = NUM_REQ'(1'b1) << grant_idx_s;
        end else begin
            req_ready = '0;
        end
    end

    assign xfer_s = |(req_ready & req_valid);

    // Stage 1 operand capture and round-robin pointer update
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr_r <= '0;
            s1_v_r   <= 1'b0;
            s1_a_r   <= '0;
            s1_b_r   <= '0;
            s1_id_r  <= '0;
        end else if (adv_s) begin
            s1_v_r <= xfer_s;
            if (xfer_s) begin
                s1_a_r  <= req_a[grant_idx_s*A_W +: A_W];
                s1_b_r  <= req_b[grant_idx_s*B_W +: B_W];
                s1_id_r <= grant_idx_s;
                if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
                    rr_ptr_r <= '0;
                end else begin
                    rr_ptr_r <= grant_idx_s + ID_W'(1);
                end
            end
        end
    end

    // The only combinational arithmetic sits between the two register stages
    assign prod_s = P_W'(s1_a_r) * P_W'(s1_b_r);

    // Stage 2 product register; frozen while the response is backpressured
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s2_v_r  <= 1'b0;
            s2_p_r  <= '0;
            s2_id_r <= '0;
        end else if (!s2_hold_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                s2_p_r  <= prod_s;
                s2_id_r <= s1_id_r;
            end
        end
    end

    assign rsp_valid = s2_v_r;
    assign rsp_p     = s2_p_r;
    assign rsp_id    = s2_id_r;
    assign busy      = s1_v_r | s2_v_r;

endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// Scoreboard bench for cnn_mul_share_arb. A cycle model predicts the grants and
// pipeline occupancy, and the expected products are queued in grant order.
module tb_cnn_mul_share_arb;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [3:0]  cfg_mask;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [39:0] req_a;
    logic [55:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [24:0] rsp_p;
    logic        busy;

    typedef struct {
        int id;
        int p;
    } sb_item_t;

    sb_item_t sb_q[$];
    int opa[4];
    int opb[4];
    int m_rr;
    bit m_s1v;
    bit m_s2v;
    int n_checks;
    int n_pass;

    cnn_mul_share_arb dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .cfg_mask (cfg_mask),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_p    (rsp_p),
        .busy     (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr  = 0;
        m_s1v = 1'b0;
        m_s2v = 1'b0;
        sb_q.delete();
    endtask

    // One cycle: called at a negedge with inputs set; checks, updates model, advances
    task automatic step();
        logic [3:0] elig;
        logic [3:0] exp_rdy;
        int g;
        bit hold;
        bit adv;
        sb_item_t it;
        for (int i = 0; i < 4; i++) begin
            req_a[i*10 +: 10] = opa[i][9:0];
            req_b[i*14 +: 14] = opb[i][13:0];
        end
        #1;
        elig = req_valid & cfg_mask;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && elig[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        end
        hold    = m_s2v && !rsp_ready;
        adv     = !m_s1v || !hold;
        exp_rdy = (adv && g >= 0) ? (4'b0001 << g) : 4'b0000;
        check_value("req_ready", int'(req_ready), int'(exp_rdy));
        check_value("rsp_valid", int'(rsp_valid), int'(m_s2v));
        check_value("busy", int'(busy), int'(m_s1v | m_s2v));
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check_value("sb_underflow", 1, 0);
            end else begin
                it = sb_q.pop_front();
                check_value("rsp_id", int'(rsp_id), it.id);
                check_value("rsp_p", int'($signed(rsp_p)), it.p);
            end
        end
        if (!hold) m_s2v = m_s1v;
        if (adv) m_s1v = (exp_rdy != 4'b0000);
        if (exp_rdy != 4'b0000) begin
            sb_q.push_back('{id: g, p: opa[g] * opb[g]});
            m_rr = (g + 1) % 4;
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic drain();
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10 && (m_s1v || m_s2v); i++) step();
        check_value("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        ap_rst_n  = 1'b0;
        cfg_mask  = 4'b1111;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < 4; i++) begin
            opa[i] = 0;
            opb[i] = 0;
        end
        model_reset();
        @(negedge ap_clk);
        @(negedge ap_clk);
        check_value("rst_ready", int'(req_ready), 0);
        check_value("rst_valid", int'(rsp_valid), 0);
        check_value("rst_p", int'(rsp_p), 0);
        check_value("rst_id", int'(rsp_id), 0);
        check_value("rst_busy", int'(busy), 0);
        req_valid = 4'b0000;
        ap_rst_n  = 1'b1;
        step();

        // Single request from requester 2
        opa[2] = -3;
        opb[2] = 1000;
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        step();
        check_value("single_lat", int'(rsp_valid), 1);
        check_value("single_p", int'($signed(rsp_p)), -3000);
        drain();

        // Round-robin fairness, all requesters valid
        for (int i = 0; i < 4; i++) begin
            opa[i] = i + 1;
            opb[i] = 10;
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 12; i++) step();
        drain();

        // Backpressure with a full pipe
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        drain();

        // Mask and operand extremes
        cfg_mask  = 4'b1010;
        opa[1] = -512;
        opb[1] = -8192;
        opa[3] = 511;
        opb[3] = -8192;
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) step();
        drain();
        cfg_mask = 4'b1111;

        // Sparse wrap 3 -> 0
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0001;
        step();
        drain();

        // Randomised traffic with a mid-stream reset
        for (int n = 0; n < 300; n++) begin
            cfg_mask  = 4'($urandom_range(0, 15));
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                opa[i] = $urandom_range(0, 1023) - 512;
                opb[i] = $urandom_range(0, 16383) - 8192;
            end
            step();
            if (n == 150) begin
                cfg_mask  = 4'b1111;
                req_valid = 4'b1111;
                rsp_ready = 1'b1;
                step();
                step();
                ap_rst_n = 1'b0;
                #1;
                check_value("mid_rst_valid", int'(rsp_valid), 0);
                check_value("mid_rst_busy", int'(busy), 0);
                check_value("mid_rst_ready", int'(req_ready), 0);
                model_reset();
                @(posedge ap_clk);
                @(negedge ap_clk);
                ap_rst_n = 1'b1;
                #1;
                check_value("rst_grant0", int'(req_ready), 1);
                step();
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
